// File: rtl/rom_smoother_pkg.sv
// rtl/rom_smoother_pkg.sv - shared types and default sizing for the ROM sample smoother
package rom_smoother_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 256;
  localparam int TAPS_LOG2_DEF  = 2;
  localparam int TAPS           = 1 << TAPS_LOG2_DEF;
  localparam int SUM_W          = WIDTH_DEF + TAPS_LOG2_DEF;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/rom_sample_smoother_window.sv
// rtl/rom_sample_smoother_window.sv - moving-average shift register with running sum
module mavg_window
  import rom_smoother_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int TAPS_LOG2 = TAPS_LOG2_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       shift_en,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH+TAPS_LOG2-1:0] sum
);

  localparam int NTAPS = 1 << TAPS_LOG2;
  localparam int SW    = WIDTH + TAPS_LOG2;

  logic [WIDTH-1:0] win_q [NTAPS];
  logic [WIDTH-1:0] win_d [NTAPS];
  logic [SW-1:0]    sum_q;
  logic [SW-1:0]    sum_d;

  // sum is the window total including din, i.e. the value loaded on a shift
  always_comb begin
    sum = sum_q + {{TAPS_LOG2{din[WIDTH-1]}}, din}
                - {{TAPS_LOG2{win_q[NTAPS-1][WIDTH-1]}}, win_q[NTAPS-1]};
    win_d = win_q;
    sum_d = sum_q;
    if (clr) begin
      for (int i = 0; i < NTAPS; i++) win_d[i] = '0;
      sum_d = '0;
    end else if (shift_en) begin
      win_d[0] = din;
      for (int i = 1; i < NTAPS; i++) win_d[i] = win_q[i-1];
      sum_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) win_q[i] <= '0;
      sum_q <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) win_q[i] <= win_d[i];
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/rom_sample_smoother.sv
// rtl/rom_sample_smoother.sv - sequences the sample ROM and streams moving-average output
module rom_sample_smoother
  import rom_smoother_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int TAPS_LOG2  = TAPS_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  loop_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NTAPS = 1 << TAPS_LOG2;
  localparam int SW    = WIDTH + TAPS_LOG2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TAPS_LOG2-1:0]  FILL_LAST = TAPS_LOG2'(NTAPS - 2);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TAPS_LOG2-1:0]  fill_q, fill_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  clr;
  logic                  shift_en;
  logic [SW-1:0]         sum;

  mavg_window #(
    .WIDTH     (WIDTH),
    .TAPS_LOG2 (TAPS_LOG2)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (rom_data),
    .sum      (sum)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    clr         = 1'b0;
    shift_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRIME;
          clr     = 1'b1;
          addr_d  = '0;
          fill_d  = '0;
        end
      end
      PRIME: begin
        shift_en = 1'b1;
        addr_d   = addr_q + ADDR_WIDTH'(1);
        fill_d   = fill_q + TAPS_LOG2'(1);
        if (fill_q == FILL_LAST) state_d = RUN;
      end
      RUN: begin
        // Fetch only into a free or freeing output slot so nothing is dropped
        if (!out_valid_q || out_ready) begin
          shift_en    = 1'b1;
          out_data_d  = WIDTH'($signed(sum) >>> TAPS_LOG2);
          out_valid_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            if (loop_en) addr_d = '0;
            else         state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rom_addr  = addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rom_sample_smoother.sv
// tb/tb_rom_sample_smoother.sv - scoreboard bench for rom_sample_smoother
module tb_rom_sample_smoother;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       loop_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] rom [256];
  logic [7:0] exp_q [$];
  logic [7:0] got [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         out_cnt  = 0;
  int         done_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  rom_sample_smoother dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] golden(int k);
    int s;
    s = 0;
    for (int j = 0; j < 4; j++) s += int'($signed(rom[(k + j) % 256]));
    s = s >>> 2;
    return s[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(golden(k));
  endtask

  task automatic wait_outs(input int n, input int limit);
    int g;
    g = 0;
    while (out_cnt < n && g < limit) begin
      tick();
      g++;
    end
    check_eq("reach_out_count", 32'(out_cnt >= n), 1);
  endtask

  task automatic wait_done(input int limit);
    int g;
    g = 0;
    while (!done && g < limit) begin
      tick();
      g++;
    end
    check_eq("done_seen", 32'(done), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consumer side: pops the scoreboard on every handshake and checks hold-under-stall
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check_eq("stall_valid_hold", 32'(out_valid), 1);
        check_eq("stall_data_hold", 32'(out_data), 32'(held_data));
      end
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("sample", 32'(out_data), 32'(exp_q.pop_front()));
        got.push_back(out_data);
        out_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int         lat;
    int         g;
    logic [7:0] a_hold;
    logic [7:0] d_hold;

    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 73 + 29) ^ (i >> 1));
    rom[0] = 8'd2;  rom[1] = 8'd6;  rom[2] = 8'd10;
    rom[3] = 8'd14; rom[4] = 8'd26; rom[5] = 8'd26;
    for (int i = 66; i < 70; i++) rom[i] = 8'hEA;
    for (int i = 253; i < 256; i++) rom[i] = 8'hF1;

    rst_n = 1'b0; start = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_rom_addr", 32'(rom_addr), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    // Single pass: latency, PRIME/RUN/DRAIN start pulses, backpressure, DONE-cycle start
    push_expected(253);
    pulse_start();
    check_eq("busy_after_start", 32'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      start = (lat == 1);
      tick();
      lat++;
    end
    start = 1'b0;
    check_eq("first_valid_latency", 32'(lat), 4);

    wait_outs(60, 400);
    out_ready = 1'b0;
    tick();
    a_hold = rom_addr;
    d_hold = out_data;
    start  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
      check_eq("bp_addr_frozen", 32'(rom_addr), 32'(a_hold));
      check_eq("bp_data_frozen", 32'(out_data), 32'(d_hold));
      check_eq("bp_valid_frozen", 32'(out_valid), 1);
    end
    out_ready = 1'b1;

    g = 0;
    while (rom_addr != 8'hFF && g < 400) begin
      tick();
      g++;
    end
    tick();
    out_ready = 1'b0;
    start     = 1'b1;
    check_eq("drain_busy", 32'(busy), 1);
    check_eq("drain_valid", 32'(out_valid), 1);
    tick();
    start = 1'b0;
    check_eq("drain_no_done", 32'(done), 0);
    tick();
    tick();
    out_ready = 1'b1;
    wait_done(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("idle_after_done", 32'(busy), 0);
    tick();
    check_eq("start_in_done_ignored", 32'(busy), 0);
    check_eq("pass_out_count", 32'(out_cnt), 253);
    check_eq("pass_sb_empty", 32'(exp_q.size()), 0);
    check_eq("pass_done_count", 32'(done_cnt), 1);
    check_eq("first_out0", 32'(got[0]), 32'h08);
    check_eq("first_out1", 32'(got[1]), 32'h0E);
    check_eq("first_out2", 32'(got[2]), 32'h13);
    check_eq("neg_floor_addr69", 32'(got[66]), 32'hEA);

    // Continuous playback across the wrap, then let the second lap finish
    got.delete();
    out_cnt = 0;
    push_expected(509);
    loop_en = 1'b1;
    pulse_start();
    wait_outs(260, 1000);
    check_eq("loop_no_done", 32'(done_cnt), 1);
    check_eq("loop_busy", 32'(busy), 1);
    check_eq("wrap_window", 32'(got[253]), 32'hF5);
    loop_en = 1'b0;
    wait_done(1000);
    tick();
    tick();
    check_eq("loop_out_count", 32'(out_cnt), 509);
    check_eq("loop_sb_empty", 32'(exp_q.size()), 0);
    check_eq("loop_done_count", 32'(done_cnt), 2);

    // Asynchronous reset mid-pass, then a clean restart
    got.delete();
    out_cnt = 0;
    push_expected(253);
    pulse_start();
    wait_outs(100, 400);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_addr", 32'(rom_addr), 0);
    check_eq("async_rst_data", 32'(out_data), 0);
    check_eq("async_rst_valid", 32'(out_valid), 0);
    check_eq("async_rst_busy", 32'(busy), 0);
    check_eq("async_rst_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    check_eq("rst_no_done", 32'(done_cnt), 2);
    got.delete();
    out_cnt = 0;
    push_expected(253);
    pulse_start();
    wait_done(600);
    tick();
    check_eq("restart_first_out", 32'(got.size() > 0 ? got[0] : 8'h00), 32'h08);
    check_eq("restart_out_count", 32'(out_cnt), 253);
    check_eq("restart_done_count", 32'(done_cnt), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_sample_smoother.md
Name: rom_sample_smoother

Overview:
- Downstream consumer of the 256x8 sample ROM (combinational read).
- Sequences the ROM address, streams the signed noisy samples through a power-of-two moving-average window, and emits filtered samples over a valid/ready handshake.
- Sits between the sample ROM and the processor's data-input port.
- Supports single-pass and continuous (wrapping) playback.

Parameters:
- WIDTH, 8, sample width, two's-complement signed.
- ADDR_WIDTH, 8, ROM address width.
- DEPTH, 256, number of ROM entries; last address is DEPTH-1.
- TAPS_LOG2, 2, log2 of window length (TAPS = 4 by default).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a pass; ignored unless IDLE.
- loop_en  in  1  1 = wrap address DEPTH-1 -> 0 and run continuously; sampled every fetch.
- rom_addr  out  ADDR_WIDTH  address to ROM.
- rom_data  in  WIDTH  ROM dout, valid in the same cycle as rom_addr.
- out_data  out  WIDTH  filtered sample, signed.
- out_valid  out  1  out_data holds an unconsumed sample.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a single pass completes.

Behaviour:
- Reset (async, rst_n=0): state IDLE, rom_addr=0, out_data=0, out_valid=0, busy=0, done=0, window registers=0, sum=0, fill counter=0.
- States: IDLE, PRIME, RUN, DRAIN, DONE.
- IDLE -> PRIME on start. On that edge: clear window/sum/fill counter and set rom_addr=0.
- Fetch:
  - On each fetch edge, rom_data is shifted into the window.
  - sum <= sum + sext(rom_data) - sext(oldest).
  - rom_addr increments; it wraps to 0 only in RUN with loop_en=1.
  - sum width is WIDTH+TAPS_LOG2, signed.
  - Result = sum_next >>> TAPS_LOG2 (arithmetic, floor), truncated to WIDTH. It cannot overflow.
- PRIME:
  - One fetch per cycle, no output.
  - After TAPS-1 fetches -> RUN, with rom_addr = TAPS-1.
- RUN:
  - Fetch only when !out_valid || out_ready (a free or freeing output slot).
  - A fetch registers the result into out_data and sets out_valid=1 on the same edge. Output latency is 1 cycle from the fetch of the window's newest sample.
  - Handshake without fetch: out_valid<=0.
  - Fetch of address DEPTH-1 with loop_en=0 -> DRAIN.
  - With loop_en=1 the window stays continuous across the wrap.
- DRAIN: hold until out_valid && out_ready, then -> DONE with out_valid<=0.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Single pass emits exactly DEPTH-TAPS+1 samples (253 by default).
- out_data and out_valid must stay stable while out_valid && !out_ready; no sample is ever dropped or duplicated.
- start in any state but IDLE is ignored.
- A start coincident with the DONE cycle is also ignored.
- Reset asserted mid-pass aborts immediately to reset values. No done pulse is produced.

Decomposition:
- Package rom_smoother_pkg holds:
  - state_t enum (IDLE, PRIME, RUN, DRAIN, DONE).
  - localparams TAPS = 1<<TAPS_LOG2 and SUM_W = WIDTH+TAPS_LOG2.
- One sub-module, mavg_window: shift register plus running-sum accumulator.
  - Inputs: clk, rst_n, clr, shift_en, din.
  - Output: sum.
- The top level holds the FSM, address counter, fill counter and output register.

Test Plan:
- Reset, start, out_ready=1, loop_en=0:
  - First four outputs are 0x08, 0x0E, 0x13, then the average of samples 3..6.
  - First out_valid appears 4 cycles after leaving IDLE.
- Negative arithmetic: the output whose newest sample is address 69 equals 0xEA (sum -88 >>> 2 = -22). This checks floor rounding on negatives.
- Backpressure:
  - Hold out_ready=0 for 5 cycles mid-RUN: out_data/out_valid stay frozen and rom_addr does not advance.
  - Release out_ready: the sequence resumes with no gap or duplicate.
  - Scoreboard against the golden model: 253 outputs, then done pulses once, busy falls, state IDLE.
- Wrap, loop_en=1: the output whose window is addresses 253,254,255,0 equals 0xF5 (sum -43 -> -11). busy stays high and no done is produced.
- Reset mid-pass: pull rst_n low at output 100 for 1 cycle.
  - All outputs return to reset values asynchronously and no done is produced.
  - A subsequent start reproduces the first output 0x08.
- start pulses during PRIME, RUN and DRAIN are ignored: output count and values are unchanged.
